// File: rtl/fourdigit_pkg.sv
// Shared types and constants for the four-digit adder board front end.
package fourdigit_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  typedef enum logic {
    SHOW_OPERANDS = 1'b0,
    SHOW_RESULT   = 1'b1
  } sel_state_t;

  // Right press wins when both buttons fire in the same cycle.
  function automatic sel_state_t sel_next(input sel_state_t cur, input logic left, input logic right);
    sel_state_t nxt;
    nxt = cur;
    if (right) begin
      nxt = SHOW_RESULT;
    end else if (left) begin
      nxt = SHOW_OPERANDS;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// One button: 2-flop synchroniser, stability counter, and registered rising-edge pulse.
import fourdigit_pkg::*;

module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_pulse    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Any sample matching the accepted level restarts the qualification run.
      if (r_sync2 != r_stable) begin
        if (r_cnt == CNT_LAST) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
      r_stable_d <= r_stable;
      r_pulse    <= r_stable & ~r_stable_d;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/button_select_ctrl.sv
// Button front end: debounced press strobes and the operand/result display selector.
import fourdigit_pkg::*;

module button_select_ctrl #(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic Button_left,
  input  logic Button_right,
  output logic display_switch,
  output logic left_pulse,
  output logic right_pulse
);

  logic       w_left_pulse;
  logic       w_right_pulse;
  logic       r_left_pulse;
  logic       r_right_pulse;
  sel_state_t r_state;
  sel_state_t w_state_next;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_left (
    .i_clk  (CLK),
    .i_rst_n(RST_n),
    .i_raw  (Button_left),
    .o_pulse(w_left_pulse)
  );

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_right (
    .i_clk  (CLK),
    .i_rst_n(RST_n),
    .i_raw  (Button_right),
    .o_pulse(w_right_pulse)
  );

  // Output strobes are registered here; the FSM reacts to the registered copies.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_left_pulse  <= 1'b0;
      r_right_pulse <= 1'b0;
      r_state       <= SHOW_OPERANDS;
    end else begin
      r_left_pulse  <= w_left_pulse;
      r_right_pulse <= w_right_pulse;
      r_state       <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_state_next = sel_next(r_state, r_left_pulse, r_right_pulse);
  end

  assign display_switch = (r_state == SHOW_RESULT);
  assign left_pulse     = r_left_pulse;
  assign right_pulse    = r_right_pulse;

endmodule

// File: tb/tb_button_select_ctrl.sv
// Self-checking bench for button_select_ctrl with DEBOUNCE_CYCLES=4.
module tb_button_select_ctrl;

  localparam int D    = 4;
  localparam int HMAX = 8192;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  logic Button_left = 1'b0;
  logic Button_right = 1'b0;
  logic display_switch;
  logic left_pulse;
  logic right_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: raw sample history per button, accepted-press edge markers.
  bit raw_h [2][HMAX];
  bit acc_h [2][HMAX];
  bit st_m  [2];
  int e_m;
  bit disp_m, lp_m, rp_m;

  typedef struct {
    bit l;
    bit r;
    bit lp;
    bit rp;
    bit disp;
  } vec_t;

  vec_t tbl [12];

  button_select_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK           (CLK),
    .RST_n         (RST_n),
    .Button_left   (Button_left),
    .Button_right  (Button_right),
    .display_switch(display_switch),
    .left_pulse    (left_pulse),
    .right_pulse   (right_pulse)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_m    = 0;
    st_m[0] = 1'b0;
    st_m[1] = 1'b0;
    disp_m = 1'b0;
    lp_m   = 1'b0;
    rp_m   = 1'b0;
  endtask

  // A level is accepted once the synchronised input (raw delayed two edges)
  // has disagreed with the accepted level for D consecutive samples.
  task automatic model_edge(input bit l, input bit r);
    raw_h[0][e_m] = l;
    raw_h[1][e_m] = r;
    for (int b = 0; b < 2; b++) begin
      bit all_diff;
      all_diff = (e_m >= D + 1);
      if (all_diff) begin
        for (int j = 0; j < D; j++) begin
          if (raw_h[b][e_m-2-j] == st_m[b]) all_diff = 1'b0;
        end
      end
      acc_h[b][e_m] = all_diff && !st_m[b];
      if (all_diff) st_m[b] = !st_m[b];
    end
    lp_m = 1'b0;
    rp_m = 1'b0;
    if (e_m >= 2) begin
      lp_m = acc_h[0][e_m-2];
      rp_m = acc_h[1][e_m-2];
    end
    if (e_m >= 3) begin
      if (acc_h[1][e_m-3]) disp_m = 1'b1;
      else if (acc_h[0][e_m-3]) disp_m = 1'b0;
    end
    if (e_m < HMAX - 1) e_m++;
  endtask

  // Called at a falling edge: drive, clock once, compare against the model.
  task automatic step(input bit l, input bit r);
    Button_left  = l;
    Button_right = r;
    @(posedge CLK);
    if (!RST_n) model_reset();
    else model_edge(l, r);
    @(negedge CLK);
    chk("model_left_pulse", left_pulse, lp_m);
    chk("model_right_pulse", right_pulse, rp_m);
    chk("model_display_switch", display_switch, disp_m);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0);
  endtask

  // Clean press held n cycles from edge 0: pulse after edge 7, display from edge 8.
  task automatic press(input string name, input bit l, input bit r, input int n, input bit exp_disp);
    for (int k = 0; k < n; k++) begin
      step(l, r);
      chk({name, "_lp"}, left_pulse, l && (k == 7));
      chk({name, "_rp"}, right_pulse, r && (k == 7));
      if (k >= 8) chk({name, "_disp"}, display_switch, exp_disp);
    end
  endtask

  initial begin
    int len;
    bit rl, rr;

    for (int k = 0; k < 12; k++) begin
      tbl[k].l    = 1'b0;
      tbl[k].r    = 1'b1;
      tbl[k].lp   = 1'b0;
      tbl[k].rp   = (k == 7);
      tbl[k].disp = (k >= 8);
    end

    model_reset();
    @(negedge CLK);

    // Reset held with buttons toggling.
    for (int k = 0; k < 6; k++) begin
      step(k[0], ~k[0]);
      chk("rst_disp", display_switch, 1'b0);
      chk("rst_lp", left_pulse, 1'b0);
      chk("rst_rp", right_pulse, 1'b0);
    end
    Button_left  = 1'b0;
    Button_right = 1'b0;
    RST_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0);
      chk("post_rst_disp", display_switch, 1'b0);
      chk("post_rst_rp", right_pulse, 1'b0);
    end

    // Clean right press, table driven.
    for (int k = 0; k < 12; k++) begin
      step(tbl[k].l, tbl[k].r);
      chk("tbl_lp", left_pulse, tbl[k].lp);
      chk("tbl_rp", right_pulse, tbl[k].rp);
      chk("tbl_disp", display_switch, tbl[k].disp);
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1);
      chk("held_no_repeat", right_pulse, 1'b0);
    end
    idle(12);

    // Bounce on right: widths shorter than D never qualify.
    for (int k = 0; k < 2; k++) begin step(1'b0, 1'b1); chk("bounce_rp", right_pulse, 1'b0); end
    step(1'b0, 1'b0); chk("bounce_rp", right_pulse, 1'b0);
    for (int k = 0; k < 3; k++) begin step(1'b0, 1'b1); chk("bounce_rp", right_pulse, 1'b0); end
    for (int k = 0; k < 2; k++) begin step(1'b0, 1'b0); chk("bounce_rp", right_pulse, 1'b0); end
    press("bounce_final", 1'b0, 1'b1, 12, 1'b1);
    idle(12);

    press("left1", 1'b1, 1'b0, 12, 1'b0);
    idle(12);
    press("left2", 1'b1, 1'b0, 12, 1'b0);
    idle(12);
    press("both", 1'b1, 1'b1, 12, 1'b1);
    idle(12);

    // Reset asserted partway through a right press.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1);
    RST_n = 1'b0;
    #1;
    chk("async_rst_disp", display_switch, 1'b0);
    chk("async_rst_rp", right_pulse, 1'b0);
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b1);
      chk("midrst_rp", right_pulse, 1'b0);
    end
    RST_n = 1'b1;
    press("after_rst", 1'b0, 1'b1, 12, 1'b1);
    idle(12);

    // Randomised segments against the model.
    for (int s = 0; s < 120; s++) begin
      rl  = 1'($urandom_range(0, 1));
      rr  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 14));
      if ($urandom_range(0, 29) == 0) begin
        RST_n = 1'b0;
        step(rl, rr);
        RST_n = 1'b1;
      end
      for (int k = 0; k < len; k++) step(rl, rr);
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
